// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the score-to-BCD converter.
// The saturation limit is the largest value that DIGITS decimal digits can show.
package score_pkg;

    localparam int SCORE_W = 20;
    localparam int DIGITS  = 6;

    // Returns 10^digits - 1, which is the largest value the display can show.
    function automatic logic [63:0] sat_limit(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] SAT_LIMIT = sat_limit(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: add 3 to a BCD digit that is 5 or more.
// Applying this before each left shift keeps the digit within 0-9.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Serial binary-to-BCD converter for the score display. It uses one double-dabble
// iteration per clock, saturates at 10^DIGITS-1, and produces leading-zero blanking enables.
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int SCORE_W = score_pkg::SCORE_W,
    parameter int DIGITS  = score_pkg::DIGITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  valid,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [63:0] SAT_WIDE = sat_limit(DIGITS);

    state_t state_reg;
    state_t state_next;

    logic [SCORE_W-1:0] bin_work_reg;
    logic [BCD_W-1:0]   bcd_work_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_work_reg;

    logic [BCD_W-1:0]   bcd_reg;
    logic [DIGITS-1:0]  digit_en_reg;
    logic               valid_reg;
    logic               busy_reg;
    logic               overflow_reg;

    logic [63:0]        score_wide;
    logic               score_over;
    logic [SCORE_W-1:0] score_sat;
    logic [BCD_W-1:0]   bcd_adj;
    logic [DIGITS-1:0]  digit_en_calc;
    logic               last_iter;

    // The input is clamped at capture time so that the value always fits in DIGITS digits.
    assign score_wide = 64'(score);
    assign score_over = (score_wide > SAT_WIDE);
    assign score_sat  = score_over ? SAT_WIDE[SCORE_W-1:0] : score;
    assign last_iter  = (cnt_reg == CNT_W'(SCORE_W - 1));

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .digit    (bcd_work_reg[4*gi +: 4]),
                .adjusted (bcd_adj[4*gi +: 4])
            );

            // A digit is lit when it or any digit above it is nonzero; the units digit is always lit.
            if (gi == 0) begin : g_units
                assign digit_en_calc[gi] = 1'b1;
            end else begin : g_upper
                assign digit_en_calc[gi] = |bcd_work_reg[BCD_W-1:4*gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bin_work_reg <= '0;
            bcd_work_reg <= '0;
            cnt_reg      <= '0;
            ovf_work_reg <= 1'b0;
            bcd_reg      <= '0;
            digit_en_reg <= DIGITS'(1);
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_work_reg <= score_sat;
                        bcd_work_reg <= '0;
                        cnt_reg      <= '0;
                        ovf_work_reg <= score_over;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_work_reg, bin_work_reg} <= {bcd_adj, bin_work_reg} << 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                DONE: begin
                    bcd_reg      <= bcd_work_reg;
                    digit_en_reg <= digit_en_calc;
                    overflow_reg <= ovf_work_reg;
                    valid_reg    <= 1'b1;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bcd      = bcd_reg;
    assign digit_en = digit_en_reg;
    assign valid    = valid_reg;
    assign busy     = busy_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter. Expected results are queued when a start is driven.
// They are compared when valid pulses, and the latency is checked against the cycle count.
module tb_score_bcd_converter;

    logic        clock;
    logic        reset;
    logic [19:0] score;
    logic        start;
    logic [23:0] bcd;
    logic [5:0]  digit_en;
    logic        valid;
    logic        busy;
    logic        overflow;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  en;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   busy_cnt  = 0;
    int   valid_cnt = 0;

    score_bcd_converter dut (
        .clock    (clock),
        .reset    (reset),
        .score    (score),
        .start    (start),
        .bcd      (bcd),
        .digit_en (digit_en),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input int unsigned s, input int c);
        exp_t e;
        int unsigned v;
        v = (s > 999999) ? 999999 : s;
        e.ovf = (s > 999999);
        e.cyc = c;
        for (int i = 0; i < 6; i++) begin
            e.bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        for (int i = 0; i < 6; i++) begin
            e.en[i] = (i == 0) || ((e.bcd >> (4*i)) != 24'd0);
        end
        return e;
    endfunction

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (busy) busy_cnt++;
        if (valid) begin
            exp_t e;
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("bcd", 64'(bcd), 64'(e.bcd));
                check_val("digit_en", 64'(digit_en), 64'(e.en));
                check_val("overflow", 64'(overflow), 64'(e.ovf));
                check_val("latency", 64'(cyc), 64'(e.cyc));
                $display("conv: bcd=%06h digit_en=%06b overflow=%0d at cycle %0d", bcd, digit_en, overflow, cyc);
            end
        end
    end

    // Start is raised at a negedge, and the DUT accepts it at the next posedge (edge k).
    // The valid pulse is expected 21 edges after edge k.
    task automatic start_conv(input int unsigned s);
        @(negedge clock);
        score = 20'(s);
        start = 1'b1;
        exp_q.push_back(model(s, cyc + 22));
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check_val("timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        start = 1'b0;
        score = '0;
        repeat (3) @(negedge clock);
        check_val("rst_bcd", 64'(bcd), 64'd0);
        check_val("rst_en", 64'(digit_en), 64'd1);
        check_val("rst_valid", 64'(valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        start_conv(0);
        wait_done();

        base = busy_cnt;
        start_conv(123456);
        wait_done();
        check_val("busy_cycles", 64'(busy_cnt - base), 64'd21);

        start_conv(1048575);
        wait_done();
        start_conv(305);
        wait_done();
        repeat (5) @(negedge clock);
        check_val("hold_bcd", 64'(bcd), 64'h000305);
        check_val("hold_en", 64'(digit_en), 64'b000111);

        // A start raised while the converter is busy must be ignored.
        base = valid_cnt;
        start_conv(42);
        repeat (3) @(negedge clock);
        start = 1'b1;
        score = 20'd7;
        repeat (5) @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (25) @(negedge clock);
        check_val("single_valid", 64'(valid_cnt - base), 64'd1);

        // Reset is applied in the middle of a conversion, sampled at the 10th SHIFT edge.
        base = valid_cnt;
        start_conv(999999);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_bcd", 64'(bcd), 64'd0);
        check_val("abort_en", 64'(digit_en), 64'd1);
        check_val("abort_ovf", 64'(overflow), 64'd0);
        repeat (30) @(negedge clock);
        check_val("abort_no_valid", 64'(valid_cnt - base), 64'd0);
        start_conv(5);
        wait_done();

        start_conv(999999);
        wait_done();
        start_conv(1000000);
        wait_done();
        for (int i = 0; i < 6; i++) begin
            start_conv($urandom_range(0, 1048575));
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_bcd_converter.md
SCORE_BCD_CONVERTER -- requirements
Module: score_bcd_converter

Interface
REQ-001 Parameter: SCORE_W, default 20, binary score width.
REQ-002 Parameter: DIGITS, default 6, BCD digits produced; saturation limit is 10^DIGITS-1 (999999 at defaults).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset; synchronous and active-high.
REQ-005 Port: score  input  SCORE_W  unsigned binary score from the game/VGA engine.
REQ-006 Port: start  input  1  conversion request; sampled only in IDLE.
REQ-007 Port: bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]; feeds the seven-segment display stage.
REQ-008 Port: digit_en  output  DIGITS  per-digit display enable; 0 marks a leading zero.
REQ-009 Port: valid  output  1  one-cycle pulse when bcd/digit_en/overflow are updated.
REQ-010 Port: busy  output  1  high while a conversion is in progress.
REQ-011 Port: overflow  output  1  last converted score exceeded 10^DIGITS-1.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge k: capture min(score, 10^DIGITS-1) into the binary working register, clear the BCD working register and iteration counter, record overflow flag internally, go to SHIFT.
REQ-014 SHIFT: each edge performs one double-dabble iteration: add 3 to every working BCD digit >= 5, then shift {bcd_work, bin_work} left by one; the counter increments.
REQ-015 After exactly SCORE_W iterations (edge k+SCORE_W), go to DONE.
REQ-016 DONE at edge k+SCORE_W+1: load bcd, digit_en, overflow output registers from working values; valid=1 for the following cycle only; go to IDLE.
REQ-017 Total latency: start accepted at edge k -> valid high in the cycle after edge k+SCORE_W+1 (21 edges at defaults).
REQ-018 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored (no queueing); start in the same cycle valid is high is accepted only if the FSM is in IDLE.
REQ-020 score changes after capture SHALL NOT affect the conversion in progress.
REQ-021 digit_en[i]=1 iff some digit j>=i is nonzero; digit_en[0] SHALL always be 1.
REQ-022 bcd, digit_en, overflow SHALL hold their last values between conversions.
REQ-023 No digit of bcd SHALL ever exceed 9.

Reset
REQ-024 reset=1 at any edge, including mid-conversion: state IDLE, counter 0, working registers 0, bcd=0, digit_en=1 (only bit 0 set), valid=0, busy=0, overflow=0.
REQ-025 reset SHALL take priority over start on the same edge.

Structure
REQ-026 Shared package score_pkg SHALL hold SCORE_W, DIGITS, the saturation constant, and the FSM state enum.
REQ-027 One sub-module, bcd_add3, SHALL implement the per-digit combinational add-3-if->=5 adjust, instantiated DIGITS times.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-029 reset, score=0, start pulse -> valid at 21st edge after start, bcd=0x000000, digit_en=000001, overflow=0.
REQ-030 score=123456, start -> bcd=0x123456, digit_en=111111, overflow=0; busy high for exactly 21 cycles.
REQ-031 score=1048575, start -> bcd=0x999999, overflow=1; then score=305, start -> bcd=0x000305, digit_en=000111, overflow=0.
REQ-032 score=42, start, then start again and score=7 during busy -> single valid pulse, bcd=0x000042.
REQ-033 start with score=999999, assert reset at 10th SHIFT edge -> next cycle busy=0, bcd=0, valid never pulses; new start with score=5 -> bcd=0x000005.
